// File: rtl/mctrl_pkg.sv
// Shared encodings for the multicycle sequencer: FSM states, RV32I opcodes,
// instruction classes and the datapath select codes it drives.
package mctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_IALU   = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5,
    CLS_LUI    = 3'd6
  } cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam int WAIT_MAX_DEF = 16;
  localparam int CNT_W_DEF    = 32;

  // R-type has no immediate; it shares code 000 with I.
  function automatic logic [2:0] imm_of_cls(input cls_t c);
    case (c)
      CLS_STORE:  return IMM_S;
      CLS_BRANCH: return IMM_B;
      CLS_JAL:    return IMM_J;
      CLS_LUI:    return IMM_U;
      default:    return IMM_I;
    endcase
  endfunction

  function automatic logic [1:0] wb_of_cls(input cls_t c);
    case (c)
      CLS_LOAD: return WB_MEM;
      CLS_JAL:  return WB_PC4;
      CLS_LUI:  return WB_IMM;
      default:  return WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/mctrl_if.sv
// Control/status bundle between multicycle_ctrl and the datapath.
// Defining MCTRL_PERF_EN adds the cycle_cnt/instret_cnt outputs.
interface mctrl_if
`ifdef MCTRL_PERF_EN
  #(parameter int CNT_W = mctrl_pkg::CNT_W_DEF)
`endif
  ;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       reg_we;
  logic [1:0] wb_sel;
  logic       alu_src;
  logic [2:0] imm_sel;
  logic       illegal;
  logic       timeout;
  logic [2:0] state_o;
`ifdef MCTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;
`endif

  modport master (
    input  opcode, zero, mem_ready,
    output ir_we, pc_we, pc_src, mem_req, mem_we, iord, reg_we,
           wb_sel, alu_src, imm_sel, illegal, timeout, state_o
`ifdef MCTRL_PERF_EN
    ,
    output cycle_cnt, instret_cnt
`endif
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ir_we, pc_we, pc_src, mem_req, mem_we, iord, reg_we,
           wb_sel, alu_src, imm_sel, illegal, timeout, state_o
`ifdef MCTRL_PERF_EN
    ,
    input  cycle_cnt, instret_cnt
`endif
  );

endinterface

// File: rtl/mctrl_decode.sv
// Combinational opcode classifier: instruction class, immediate format and
// unsupported-opcode flag for the DECODE state.
module mctrl_decode
  import mctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls,
  output logic [2:0] imm_sel,
  output logic       illegal
);

  always_comb begin
    cls     = CLS_R;
    illegal = 1'b0;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_IALU:   cls = CLS_IALU;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JAL:    cls = CLS_JAL;
      OP_LUI:    cls = CLS_LUI;
      default:   illegal = 1'b1;
    endcase
  end

  assign imm_sel = imm_of_cls(cls);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with shared-memory wait timeout.
// Defining MCTRL_PERF_EN adds wrapping cycle and retired-instruction counters.
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
`ifdef MCTRL_PERF_EN
  ,
  parameter int CNT_W = CNT_W_DEF
`endif
) (
  input logic     CLK,
  input logic     RST,
  mctrl_if.master bus
);

  localparam int WCNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  state_t            state, state_nx;
  cls_t              cls_q, dec_cls;
  logic [2:0]        dec_imm;
  logic              dec_illegal;
  logic [WCNT_W-1:0] wait_cnt;
  logic              illegal_q, timeout_q;
  logic              stall, expire;

  logic       ir_we, pc_we, mem_req, mem_we, iord, reg_we, alu_src;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] imm_sel;

  mctrl_decode u_decode (
    .opcode  (bus.opcode),
    .cls     (dec_cls),
    .imm_sel (dec_imm),
    .illegal (dec_illegal)
  );

  // The last permitted wait cycle traps unless mem_ready arrives in it.
  assign stall  = mem_req && !bus.mem_ready;
  assign expire = stall && (wait_cnt == WCNT_W'(WAIT_MAX - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   state_nx = ST_FETCH;
      ST_FETCH:  if (bus.mem_ready) state_nx = ST_DECODE;
                 else if (expire)   state_nx = ST_TRAP;
      ST_DECODE: state_nx = dec_illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (cls_q)
          CLS_BRANCH:          state_nx = ST_FETCH;
          CLS_LOAD, CLS_STORE: state_nx = ST_MEM;
          default:             state_nx = ST_WB;
        endcase
      end
      ST_MEM:    if (bus.mem_ready) state_nx = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
                 else if (expire)   state_nx = ST_TRAP;
      ST_WB:     state_nx = ST_FETCH;
      ST_TRAP:   state_nx = ST_TRAP;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_src  = PC_PLUS4;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    iord    = 1'b0;
    reg_we  = 1'b0;
    wb_sel  = WB_ALU;
    alu_src = 1'b0;
    imm_sel = IMM_I;
    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = bus.mem_ready;
      end
      ST_DECODE: imm_sel = dec_imm;
      ST_EXEC: begin
        imm_sel = imm_of_cls(cls_q);
        alu_src = (cls_q == CLS_IALU) || (cls_q == CLS_LOAD) || (cls_q == CLS_STORE);
        if (cls_q == CLS_BRANCH) begin
          pc_we  = 1'b1;
          pc_src = bus.zero ? PC_IMM : PC_PLUS4;
        end
      end
      ST_MEM: begin
        imm_sel = imm_of_cls(cls_q);
        mem_req = 1'b1;
        iord    = 1'b1;
        alu_src = 1'b1;
        mem_we  = (cls_q == CLS_STORE);
        pc_we   = (cls_q == CLS_STORE) && bus.mem_ready;
      end
      ST_WB: begin
        imm_sel = imm_of_cls(cls_q);
        reg_we  = 1'b1;
        wb_sel  = wb_of_cls(cls_q);
        pc_we   = 1'b1;
        pc_src  = (cls_q == CLS_JAL) ? PC_IMM : PC_PLUS4;
      end
      default: ;
    endcase
  end

  // Wait counter restarts on every state change, so it only spans one access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt  <= '0;
      cls_q     <= CLS_R;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (state_nx != state) wait_cnt <= '0;
      else if (stall)        wait_cnt <= wait_cnt + WCNT_W'(1);
      if (state == ST_DECODE) begin
        cls_q <= dec_cls;
        if (dec_illegal) illegal_q <= 1'b1;
      end
      if (expire) timeout_q <= 1'b1;
    end
  end

`ifdef MCTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != ST_IDLE && state != ST_TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (pc_we) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

  assign bus.cycle_cnt   = cycle_cnt;
  assign bus.instret_cnt = instret_cnt;
`endif

  assign bus.ir_we   = ir_we;
  assign bus.pc_we   = pc_we;
  assign bus.pc_src  = pc_src;
  assign bus.mem_req = mem_req;
  assign bus.mem_we  = mem_we;
  assign bus.iord    = iord;
  assign bus.reg_we  = reg_we;
  assign bus.wb_sel  = wb_sel;
  assign bus.alu_src = alu_src;
  assign bus.imm_sel = imm_sel;
  assign bus.illegal = illegal_q;
  assign bus.timeout = timeout_q;
  assign bus.state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle sequences built from
// the instruction-class rules, played against random memory waits and opcodes.
module tb_multicycle_ctrl;

  localparam int WAIT_MAX = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  mctrl_if bus ();

  multicycle_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       alu_src;
    logic [2:0] imm_sel;
    logic       ill;
    logic       to;
  } outs_t;

  typedef struct {
    logic       rdy;
    logic       z;
    logic [6:0] op;
    outs_t      o;
  } step_t;

  step_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic ill_m = 1'b0;
  logic to_m  = 1'b0;
  int unsigned cyc_m = 0;
  int unsigned ret_m = 0;

  logic [6:0] legal_ops [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b0110111};
  logic [2:0] imm_tab [7]   = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [1:0] wb_tab  [7]   = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd3};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cls_of(input logic [6:0] op);
    for (int i = 0; i < 7; i++)
      if (legal_ops[i] == op) return i;
    return -1;
  endfunction

  function automatic logic [18:0] got_vec();
    return {bus.state_o, bus.ir_we, bus.pc_we, bus.pc_src, bus.mem_req, bus.mem_we,
            bus.iord, bus.reg_we, bus.wb_sel, bus.alu_src, bus.imm_sel,
            bus.illegal, bus.timeout};
  endfunction

  function automatic outs_t base(input int st);
    outs_t o;
    o     = '0;
    o.st  = 3'(st);
    o.ill = ill_m;
    o.to  = to_m;
    return o;
  endfunction

  task automatic push(input outs_t o, input logic rdy, input logic z, input logic [6:0] op);
    step_t s;
    s.rdy = rdy;
    s.z   = z;
    s.op  = op;
    s.o   = o;
    q.push_back(s);
  endtask

  // Expected cycles of one instruction; fw/mw are stall cycles before mem_ready.
  task automatic build(input logic [6:0] op, input logic zb, input int fw, input int mw,
                       output bit trapped);
    int c;
    outs_t o;
    logic [2:0] imm;
    c = cls_of(op);
    trapped = 1'b0;
    imm = (c < 0) ? 3'd0 : imm_tab[c];
    for (int i = 0; i < fw && i < WAIT_MAX; i++) begin
      o = base(1); o.mem_req = 1'b1;
      push(o, 1'b0, 1'($urandom), 7'($urandom));
    end
    if (fw >= WAIT_MAX) begin to_m = 1'b1; trapped = 1'b1; return; end
    o = base(1); o.mem_req = 1'b1; o.ir_we = 1'b1;
    push(o, 1'b1, 1'($urandom), 7'($urandom));
    o = base(2); o.imm_sel = imm;
    push(o, 1'($urandom), 1'($urandom), op);
    if (c < 0) begin ill_m = 1'b1; trapped = 1'b1; return; end
    o = base(3); o.imm_sel = imm; o.alu_src = (c >= 1 && c <= 3);
    if (c == 4) begin
      o.pc_we = 1'b1; o.pc_src = zb ? 2'b01 : 2'b00;
      push(o, 1'($urandom), zb, 7'($urandom));
      return;
    end
    push(o, 1'($urandom), 1'($urandom), 7'($urandom));
    if (c == 2 || c == 3) begin
      for (int i = 0; i < mw && i < WAIT_MAX; i++) begin
        o = base(4); o.imm_sel = imm; o.mem_req = 1'b1; o.iord = 1'b1;
        o.alu_src = 1'b1; o.mem_we = (c == 3);
        push(o, 1'b0, 1'($urandom), 7'($urandom));
      end
      if (mw >= WAIT_MAX) begin to_m = 1'b1; trapped = 1'b1; return; end
      o = base(4); o.imm_sel = imm; o.mem_req = 1'b1; o.iord = 1'b1;
      o.alu_src = 1'b1; o.mem_we = (c == 3); o.pc_we = (c == 3);
      push(o, 1'b1, 1'($urandom), 7'($urandom));
      if (c == 3) return;
    end
    o = base(5); o.imm_sel = imm; o.reg_we = 1'b1; o.wb_sel = wb_tab[c];
    o.pc_we = 1'b1; o.pc_src = (c == 5) ? 2'b01 : 2'b00;
    push(o, 1'($urandom), 1'($urandom), 7'($urandom));
  endtask

  task automatic add_trap(input int n);
    repeat (n) push(base(6), 1'($urandom), 1'($urandom), 7'($urandom));
  endtask

  task automatic play(input int limit);
    step_t s;
    int k;
    k = 0;
    while (q.size() > 0 && k < limit) begin
      s = q.pop_front();
      @(negedge CLK);
      bus.mem_ready = s.rdy;
      bus.zero      = s.z;
      bus.opcode    = s.op;
      #1;
      chk($sformatf("cycle_st%0d", s.o.st), 64'(got_vec()), 64'(s.o));
`ifdef MCTRL_PERF_EN
      chk("cycle_cnt", 64'(bus.cycle_cnt), 64'(cyc_m));
      chk("instret_cnt", 64'(bus.instret_cnt), 64'(ret_m));
`endif
      if (s.o.st != 3'd0 && s.o.st != 3'd6) cyc_m++;
      if (s.o.pc_we) ret_m++;
      k++;
    end
    q.delete();
  endtask

  // Asynchronous pulse issued between clock edges; outputs must clear at once.
  task automatic reset_pulse();
    RST = 1'b1;
    #1;
    chk("reset_outputs", 64'(got_vec()), 64'd0);
`ifdef MCTRL_PERF_EN
    chk("reset_cycle_cnt", 64'(bus.cycle_cnt), 64'd0);
    chk("reset_instret_cnt", 64'(bus.instret_cnt), 64'd0);
`endif
    ill_m = 1'b0; to_m = 1'b0; cyc_m = 0; ret_m = 0;
    RST = 1'b0;
    #1;
    chk("idle_outputs", 64'(got_vec()), 64'd0);
  endtask

  logic [6:0] op;
  int fw, mw;
  bit tr;

  initial begin
    bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    #1;
    reset_pulse();

    build(7'b0110011, 1'b0, 0, 0, tr); play(100);
    build(7'b0000011, 1'b0, 0, 3, tr); play(100);
    build(7'b1100011, 1'b1, 0, 0, tr); play(100);
    build(7'b1100011, 1'b0, 0, 0, tr); play(100);
    build(7'b1101111, 1'b0, 0, 0, tr); play(100);
    build(7'b0110111, 1'b0, 0, 0, tr); play(100);
    build(7'b0100011, 1'b0, 2, 1, tr); play(100);
    build(7'b0010011, 1'b0, WAIT_MAX - 1, 0, tr); play(100);
    build(7'b0000011, 1'b0, 0, WAIT_MAX - 1, tr); play(100);

    for (int n = 0; n < 60; n++) begin
      op = legal_ops[$urandom_range(0, 6)];
      fw = ($urandom_range(0, 7) == 0) ? WAIT_MAX - 1 : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 7) == 0) ? WAIT_MAX - 1 : int'($urandom_range(0, 3));
      build(op, 1'($urandom), fw, mw, tr);
      play(200);
    end

    build(7'h7F, 1'b0, 1, 0, tr); add_trap(20); play(200);
    reset_pulse();

    do op = 7'($urandom); while (cls_of(op) >= 0);
    build(op, 1'b0, 0, 0, tr); add_trap(5); play(100);
    reset_pulse();

    build(7'b0110011, 1'b0, WAIT_MAX, 0, tr); add_trap(5); play(100);
    reset_pulse();

    build(7'b0000011, 1'b0, 1, WAIT_MAX, tr); add_trap(5); play(100);
    reset_pulse();

    // STORE stalled in MEM: stop after fetch, decode, exec and one MEM wait.
    build(7'b0100011, 1'b0, 0, 5, tr); play(4);
    reset_pulse();

    build(7'b0110011, 1'b0, 0, 0, tr); play(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
